// File: rtl/ddr_pkg.sv
// ddr_pkg: command encodings, request/bank types and FSM states shared by the DDR4 command issuer
package ddr_pkg;
    // {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}; ACT_C carries row[14] in its last bit at issue time
    localparam logic [4:0] ACT_C = 5'b00000;
    localparam logic [4:0] WR_C  = 5'b01100;
    localparam logic [4:0] RD_C  = 5'b01101;
    localparam logic [4:0] PRE_C = 5'b01010;
    localparam logic [4:0] NOP_C = 5'b11111;
    typedef enum logic {WR_R = 1'b0, RD_R = 1'b1} req_type_e;
    typedef struct packed {
        logic        open;
        logic [14:0] row;
    } bank_entry_t;
    typedef enum logic [2:0] {IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_DATA} state_e;
endpackage

// File: rtl/bank_row_table.sv
// bank_row_table: open-row tracker for 16 banks indexed {bg,ba}
//   CK_t/reset_n      clock, async active-low clear (all banks closed)
//   lk_idx/lk_row     lookup -> hit (open, same row), miss (open, other row)
//   set_en/idx/row    mark bank open with row; clr_en/idx mark bank closed
module bank_row_table
    import ddr_pkg::*;
(
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic [3:0]  lk_idx,
    input  logic [14:0] lk_row,
    output logic        hit,
    output logic        miss,
    input  logic        set_en,
    input  logic [3:0]  set_idx,
    input  logic [14:0] set_row,
    input  logic        clr_en,
    input  logic [3:0]  clr_idx
);
    bank_entry_t tbl [16];

    assign hit  = tbl[lk_idx].open && (tbl[lk_idx].row == lk_row);
    assign miss = tbl[lk_idx].open && (tbl[lk_idx].row != lk_row);

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) tbl[i] <= '0;
        end else begin
            if (clr_en) tbl[clr_idx].open <= 1'b0;
            if (set_en) tbl[set_idx] <= bank_entry_t'({1'b1, set_row});
        end
    end
endmodule

// File: rtl/ddr_cmd_issuer.sv
// ddr_cmd_issuer: single-request DDR4 PRE/ACT/RD/WR issuer with tRP/tRAS/tRCD spacing and data-timing pulses
//   CK_t/reset_n                    clock, async active-low reset
//   req_*/BL                        request handshake and fields (req_ready high only in IDLE)
//   cs_n..WE_n_A14, bg/ba, A13..A0  CA bus, NOP with zero address when idle
//   wr_burst_start/rd_data_start    data launch/capture pulses; done marks completion
module ddr_cmd_issuer
    import ddr_pkg::*;
#(
    parameter int T_RCD = 11,
    parameter int T_RP  = 11,
    parameter int T_RAS = 28,
    parameter int CL    = 11,
    parameter int CWL   = 9
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_type,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [14:0] req_row,
    input  logic [9:0]  req_col,
    input  logic [3:0]  BL,
    output logic        cs_n,
    output logic        act_n,
    output logic        RAS_n_A16,
    output logic        CAS_n_A15,
    output logic        WE_n_A14,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic        A13,
    output logic        A12_BC_n,
    output logic        A11,
    output logic        A10_AP,
    output logic [9:0]  A9_A0,
    output logic        wr_burst_start,
    output logic        rd_data_start,
    output logic        done
);
    localparam int RW = $clog2(T_RAS + 1);

    state_e      state, next;
    logic [7:0]  cnt;
    logic [RW-1:0] ras_cnt;
    req_type_e   r_type;
    logic [1:0]  r_bg, r_ba;
    logic [14:0] r_row;
    logic [9:0]  r_col;
    logic        r_bl8;
    logic        hit, miss, ras_ok, r_rd;
    logic [4:0]  cmd;
    logic [13:0] addr;
    logic [7:0]  done_at;

    assign req_ready = (state == IDLE);
    assign ras_ok    = ras_cnt >= RW'(T_RAS);
    assign r_rd      = (r_type == RD_R);
    // done lands latency + BL/2 cycles after CAS; cnt is 0 on the cycle after CAS
    assign done_at   = (r_rd ? 8'(CL) : 8'(CWL)) + (r_bl8 ? 8'd3 : 8'd1);
    assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = cmd;
    assign {A13, A12_BC_n, A11, A10_AP, A9_A0} = addr;

    bank_row_table u_tbl (
        .CK_t    (CK_t),
        .reset_n (reset_n),
        .lk_idx  ({req_bg, req_ba}),
        .lk_row  (req_row),
        .hit     (hit),
        .miss    (miss),
        .set_en  (state == ACT),
        .set_idx ({r_bg, r_ba}),
        .set_row (r_row),
        .clr_en  (state == PRE && ras_ok),
        .clr_idx ({r_bg, r_ba})
    );

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ras_cnt <= RW'(T_RAS);
            r_type  <= WR_R;
            r_bg    <= '0;
            r_ba    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_bl8   <= 1'b0;
        end else begin
            state   <= next;
            // cnt counts cycles spent in the current wait state, starting at 0
            cnt     <= (next != state) ? '0 : cnt + 8'd1;
            ras_cnt <= (state == ACT) ? '0 : ras_ok ? ras_cnt : ras_cnt + RW'(1);
            if (req_valid && state == IDLE) begin
                r_type <= req_type_e'(req_type);
                r_bg   <= req_bg;
                r_ba   <= req_ba;
                r_row  <= req_row;
                r_col  <= req_col;
                r_bl8  <= (BL != 4'd4);
            end
        end
    end

    always_comb begin
        next           = state;
        cmd            = NOP_C;
        addr           = '0;
        bg_addr        = '0;
        ba_addr        = '0;
        wr_burst_start = 1'b0;
        rd_data_start  = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE:      if (req_valid) next = hit ? CAS : miss ? PRE : ACT;
            PRE:       if (ras_ok) begin
                           cmd     = PRE_C;
                           bg_addr = r_bg;
                           ba_addr = r_ba;
                           next    = WAIT_RP;
                       end
            WAIT_RP:   if (cnt == 8'(T_RP - 2)) next = ACT;
            ACT:       begin
                           cmd     = {ACT_C[4:1], r_row[14]};
                           addr    = r_row[13:0];
                           bg_addr = r_bg;
                           ba_addr = r_ba;
                           next    = WAIT_RCD;
                       end
            WAIT_RCD:  if (cnt == 8'(T_RCD - 2)) next = CAS;
            CAS:       begin
                           cmd     = r_rd ? RD_C : WR_C;
                           addr    = {1'b0, r_bl8, 2'b00, r_col};
                           bg_addr = r_bg;
                           ba_addr = r_ba;
                           next    = WAIT_DATA;
                       end
            WAIT_DATA: begin
                           wr_burst_start = !r_rd && cnt == 8'(CWL - 1);
                           rd_data_start  = r_rd && cnt == 8'(CL - 1);
                           done           = (cnt == done_at);
                           next           = done ? IDLE : WAIT_DATA;
                       end
            default:   next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// tb_ddr_cmd_issuer: directed checks of command sequencing, pin encoding and data timing
module tb_ddr_cmd_issuer;
    import ddr_pkg::*;

    logic        CK_t = 1'b0, reset_n = 1'b0;
    logic        req_valid = 1'b0, req_type = 1'b0;
    logic [1:0]  req_bg = '0, req_ba = '0;
    logic [14:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic [3:0]  BL = 4'd8;
    logic        req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [1:0]  bg_addr, ba_addr;
    logic        A13, A12_BC_n, A11, A10_AP;
    logic [9:0]  A9_A0;
    logic        wr_burst_start, rd_data_start, done;
    logic [4:0]  cmd;

    int checks = 0, errors = 0, cyc = 0;
    int n_act = 0, n_pre = 0, n_cas = 0, n_wbs = 0, n_rds = 0, n_done = 0, n_nop_bad = 0;
    int act_cyc = -1, pre_cyc = -1, cas_cyc = -1, wbs_cyc = -1, rds_cyc = -1, done_cyc = -1, rdy_cyc = -1;
    logic [14:0] act_row;
    logic [1:0]  act_bg, act_ba, pre_bg, pre_ba, cas_bg, cas_ba;
    logic        cas_rd, cas_bc, pre_a10, cas_a10, prev_rdy = 1'b1;
    logic [9:0]  cas_col;

    ddr_cmd_issuer dut (
        .CK_t(CK_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .req_col(req_col), .BL(BL), .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
        .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .bg_addr(bg_addr), .ba_addr(ba_addr),
        .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
        .wr_burst_start(wr_burst_start), .rd_data_start(rd_data_start), .done(done)
    );

    assign cmd = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};

    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc++;

    always @(negedge CK_t) begin
        if (!cs_n && !act_n) begin
            n_act++; act_cyc = cyc; act_bg = bg_addr; act_ba = ba_addr;
            act_row = {WE_n_A14, A13, A12_BC_n, A11, A10_AP, A9_A0};
        end else if (cmd == PRE_C) begin
            n_pre++; pre_cyc = cyc; pre_a10 = A10_AP; pre_bg = bg_addr; pre_ba = ba_addr;
        end else if (cmd == RD_C || cmd == WR_C) begin
            n_cas++; cas_cyc = cyc; cas_rd = (cmd == RD_C); cas_col = A9_A0;
            cas_bc = A12_BC_n; cas_a10 = A10_AP; cas_bg = bg_addr; cas_ba = ba_addr;
        end else if ({bg_addr, ba_addr, A13, A12_BC_n, A11, A10_AP, A9_A0} != '0) begin
            n_nop_bad++;
        end
        if (wr_burst_start) begin n_wbs++; wbs_cyc = cyc; end
        if (rd_data_start) begin n_rds++; rds_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (req_ready && !prev_rdy) rdy_cyc = cyc;
        prev_rdy = req_ready;
    end

    task automatic send(input logic t, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [14:0] row, input logic [9:0] col, input logic [3:0] bl,
                        output int tc);
        int n = 0;
        @(negedge CK_t);
        while (!req_ready && n < 200) begin @(negedge CK_t); n++; end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL send_ready got %b exp 1", req_ready); end
        req_valid = 1'b1; req_type = t; req_bg = bg; req_ba = ba; req_row = row; req_col = col; BL = bl;
        tc = cyc;
        @(posedge CK_t);
        #1;
        req_valid = 1'b0; req_type = ~t; req_bg = ~bg; req_row = 15'($urandom); req_col = 10'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CK_t);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        checks++; if (cmd !== NOP_C) begin errors++; $display("FAIL rst_cmd got %b exp %b", cmd, NOP_C); end
        checks++; if ({A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr} !== '0) begin errors++; $display("FAIL rst_addr got nonzero exp 0"); end
        checks++; if ({wr_burst_start, rd_data_start, done} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {wr_burst_start, rd_data_start, done}); end
        repeat (3) @(negedge CK_t);
        reset_n = 1'b1;
        idle(2);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
    endtask

    task automatic test_closed_wr();
        int tc, b_act = n_act, b_pre = n_pre;
        send(1'b0, 2'd0, 2'd0, 15'd5, 10'd8, 4'd8, tc);
        idle(40);
        checks++; if (act_cyc !== tc + 1) begin errors++; $display("FAIL cw_act_cyc got %0d exp %0d", act_cyc, tc + 1); end
        checks++; if (act_row !== 15'd5) begin errors++; $display("FAIL cw_act_row got %0d exp 5", act_row); end
        checks++; if (n_act - b_act !== 1 || n_pre - b_pre !== 0) begin errors++; $display("FAIL cw_cmd_count got act %0d pre %0d exp 1 0", n_act - b_act, n_pre - b_pre); end
        checks++; if (cas_cyc !== tc + 12 || cas_rd !== 1'b0) begin errors++; $display("FAIL cw_wr got cyc %0d rd %b exp %0d 0", cas_cyc, cas_rd, tc + 12); end
        checks++; if ({cas_col, cas_bc, cas_a10} !== {10'd8, 1'b1, 1'b0}) begin errors++; $display("FAIL cw_wr_pins got col %0d bc %b ap %b exp 8 1 0", cas_col, cas_bc, cas_a10); end
        checks++; if (wbs_cyc !== tc + 21) begin errors++; $display("FAIL cw_wbs got %0d exp %0d", wbs_cyc, tc + 21); end
        checks++; if (done_cyc !== tc + 25) begin errors++; $display("FAIL cw_done got %0d exp %0d", done_cyc, tc + 25); end
        checks++; if (rdy_cyc !== tc + 26) begin errors++; $display("FAIL cw_ready got %0d exp %0d", rdy_cyc, tc + 26); end
    endtask

    task automatic test_hit_rd();
        int tc, b_act = n_act, b_pre = n_pre;
        send(1'b1, 2'd0, 2'd0, 15'd5, 10'd16, 4'd8, tc);
        idle(30);
        checks++; if (cas_cyc !== tc + 1 || cas_rd !== 1'b1 || cas_col !== 10'd16) begin errors++; $display("FAIL hit_rd got cyc %0d rd %b col %0d exp %0d 1 16", cas_cyc, cas_rd, cas_col, tc + 1); end
        checks++; if (n_act - b_act !== 0 || n_pre - b_pre !== 0) begin errors++; $display("FAIL hit_no_act got act %0d pre %0d exp 0 0", n_act - b_act, n_pre - b_pre); end
        checks++; if (rds_cyc !== tc + 12) begin errors++; $display("FAIL hit_rds got %0d exp %0d", rds_cyc, tc + 12); end
        checks++; if (done_cyc !== tc + 16) begin errors++; $display("FAIL hit_done got %0d exp %0d", done_cyc, tc + 16); end
    endtask

    task automatic test_row_miss();
        int tc1, tc2, b_act, b_pre;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        b_act = n_act; b_pre = n_pre;
        send(1'b0, 2'd0, 2'd0, 15'd5, 10'd0, 4'd8, tc1);
        send(1'b1, 2'd0, 2'd0, 15'd9, 10'd4, 4'd8, tc2);
        idle(80);
        checks++; if (tc2 !== tc1 + 26) begin errors++; $display("FAIL miss_accept got %0d exp %0d", tc2, tc1 + 26); end
        checks++; if (pre_cyc < tc1 + 1 + 28 || pre_cyc > tc2 + 40) begin errors++; $display("FAIL miss_pre_tras got %0d exp >= %0d", pre_cyc, tc1 + 29); end
        checks++; if ({pre_a10, pre_bg, pre_ba} !== 5'b0) begin errors++; $display("FAIL miss_pre_pins got %b exp 0", {pre_a10, pre_bg, pre_ba}); end
        checks++; if (act_cyc !== pre_cyc + 11 || act_row !== 15'd9) begin errors++; $display("FAIL miss_act got cyc %0d row %0d exp %0d 9", act_cyc, act_row, pre_cyc + 11); end
        checks++; if (n_act - b_act !== 2 || n_pre - b_pre !== 1) begin errors++; $display("FAIL miss_counts got act %0d pre %0d exp 2 1", n_act - b_act, n_pre - b_pre); end
        checks++; if (cas_cyc !== act_cyc + 11 || cas_rd !== 1'b1) begin errors++; $display("FAIL miss_rd got cyc %0d rd %b exp %0d 1", cas_cyc, cas_rd, act_cyc + 11); end
        checks++; if (rds_cyc !== cas_cyc + 11 || done_cyc !== cas_cyc + 15) begin errors++; $display("FAIL miss_data got rds %0d done %0d exp %0d %0d", rds_cyc, done_cyc, cas_cyc + 11, cas_cyc + 15); end
    endtask

    task automatic test_banks();
        int tc, b_act, b_pre;
        send(1'b0, 2'd1, 2'd2, 15'd3, 10'd1, 4'd8, tc);
        idle(30);
        checks++; if ({act_bg, act_ba, act_row} !== {2'd1, 2'd2, 15'd3} || act_cyc !== tc + 1) begin errors++; $display("FAIL bank_act_a got bg %0d ba %0d row %0d exp 1 2 3", act_bg, act_ba, act_row); end
        send(1'b1, 2'd3, 2'd1, 15'd7, 10'd2, 4'd8, tc);
        idle(30);
        checks++; if ({act_bg, act_ba, act_row} !== {2'd3, 2'd1, 15'd7} || act_cyc !== tc + 1) begin errors++; $display("FAIL bank_act_b got bg %0d ba %0d row %0d exp 3 1 7", act_bg, act_ba, act_row); end
        b_act = n_act; b_pre = n_pre;
        send(1'b1, 2'd1, 2'd2, 15'd3, 10'd3, 4'd8, tc);
        idle(20);
        checks++; if (cas_cyc !== tc + 1 || {cas_bg, cas_ba} !== {2'd1, 2'd2}) begin errors++; $display("FAIL bank_hit_a got cyc %0d bgba %b exp %0d 0110", cas_cyc, {cas_bg, cas_ba}, tc + 1); end
        send(1'b0, 2'd3, 2'd1, 15'd7, 10'd4, 4'd8, tc);
        idle(20);
        checks++; if (cas_cyc !== tc + 1 || {cas_bg, cas_ba} !== {2'd3, 2'd1}) begin errors++; $display("FAIL bank_hit_b got cyc %0d bgba %b exp %0d 1101", cas_cyc, {cas_bg, cas_ba}, tc + 1); end
        checks++; if (n_act - b_act !== 0 || n_pre - b_pre !== 0) begin errors++; $display("FAIL bank_no_act got act %0d pre %0d exp 0 0", n_act - b_act, n_pre - b_pre); end
    endtask

    task automatic test_bl4();
        int tc;
        send(1'b0, 2'd3, 2'd1, 15'd7, 10'h3FF, 4'd4, tc);
        idle(20);
        checks++; if (cas_cyc !== tc + 1 || cas_bc !== 1'b0 || cas_col !== 10'h3FF) begin errors++; $display("FAIL bl4_wr got cyc %0d bc %b col %h exp %0d 0 3ff", cas_cyc, cas_bc, cas_col, tc + 1); end
        checks++; if (wbs_cyc !== tc + 10 || done_cyc !== tc + 12) begin errors++; $display("FAIL bl4_timing got wbs %0d done %0d exp %0d %0d", wbs_cyc, done_cyc, tc + 10, tc + 12); end
        send(1'b1, 2'd3, 2'd1, 15'd7, 10'd5, 4'd5, tc);
        idle(20);
        checks++; if (cas_bc !== 1'b1 || done_cyc !== tc + 16) begin errors++; $display("FAIL bl_odd_as8 got bc %b done %0d exp 1 %0d", cas_bc, done_cyc, tc + 16); end
    endtask

    task automatic test_reset_mid();
        int tc, b_act, b_cas, b_wbs, b_rds, b_done;
        send(1'b0, 2'd2, 2'd3, 15'h7ABC, 10'd1, 4'd8, tc);
        repeat (5) @(negedge CK_t);
        checks++; if (act_cyc !== tc + 1 || act_row !== 15'h7ABC || {act_bg, act_ba} !== 4'b1011) begin errors++; $display("FAIL rm_act got cyc %0d row %h exp %0d 7abc", act_cyc, act_row, tc + 1); end
        b_cas = n_cas; b_wbs = n_wbs; b_rds = n_rds; b_done = n_done;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cmd !== NOP_C || req_ready !== 1'b1) begin errors++; $display("FAIL rm_nop got cmd %b ready %b exp %b 1", cmd, req_ready, NOP_C); end
        repeat (3) @(negedge CK_t);
        reset_n = 1'b1;
        idle(30);
        checks++; if (n_cas - b_cas !== 0 || n_wbs - b_wbs !== 0 || n_rds - b_rds !== 0 || n_done - b_done !== 0) begin errors++; $display("FAIL rm_no_events got cas %0d wbs %0d rds %0d done %0d exp 0", n_cas - b_cas, n_wbs - b_wbs, n_rds - b_rds, n_done - b_done); end
        b_act = n_act;
        send(1'b1, 2'd2, 2'd3, 15'h7ABC, 10'd2, 4'd8, tc);
        idle(40);
        checks++; if (n_act - b_act !== 1 || act_cyc !== tc + 1) begin errors++; $display("FAIL rm_reopen got act %0d cyc %0d exp 1 %0d", n_act - b_act, act_cyc, tc + 1); end
        checks++; if (cas_cyc !== tc + 12 || rds_cyc !== tc + 23 || done_cyc !== tc + 27) begin errors++; $display("FAIL rm_rd got cas %0d rds %0d done %0d exp %0d %0d %0d", cas_cyc, rds_cyc, done_cyc, tc + 12, tc + 23, tc + 27); end
        checks++; if (n_nop_bad !== 0) begin errors++; $display("FAIL nop_addr got %0d exp 0", n_nop_bad); end
    endtask

    initial begin
        test_reset();
        test_closed_wr();
        test_hit_rd();
        test_row_miss();
        test_banks();
        test_bl4();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
